// File: rtl/dglk_bram_arbiter.sv
// rtl/dglk_bram_arbiter.sv - block RAM access controller: zero-fill, write pass-through, round-robin A/B reads
//
// Purpose: after reset, zero-fills the attached simple dual-port RAM. It then
// passes the single writer straight to the write port. It also shares the
// registered read port between requesters A and B using round-robin arbitration.
// Optional build macro: DGLK_ARB_FWD_EN. When defined, a read that collides
// with a write to the same address in the same cycle returns the new data.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data     write request; wr_gnt accepts it (combinational)
//   rd_req_x/rd_addr_x         read request per requester (x = a, b)
//   rd_gnt_x                   read accepted this cycle (combinational)
//   rd_vld_x/rd_data_x         read return strobe and held data (grant + 2 cycles)
//   ram_w_ena/addr/data        RAM write port
//   ram_r_addr/ram_r_data      RAM read port (data valid one cycle after address)
//   init_done                  high once zero-fill has completed
module dglk_bram_arbiter #(
  parameter int DW = 40,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_req_a,
  input  logic [AW-1:0] rd_addr_a,
  output logic          rd_gnt_a,
  output logic          rd_vld_a,
  output logic [DW-1:0] rd_data_a,
  input  logic          rd_req_b,
  input  logic [AW-1:0] rd_addr_b,
  output logic          rd_gnt_b,
  output logic          rd_vld_b,
  output logic [DW-1:0] rd_data_b,
  output logic          ram_w_ena,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data,
  output logic          init_done
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] init_cnt_q;
  logic          prio_q;      // 0: A wins a contended cycle, 1: B wins
  logic [AW-1:0] r_addr_q;    // last presented read address, held while idle
  logic          s1_vld_q;
  logic          s1_id_q;     // 0: A, 1: B
  logic [DW-1:0] ret_data;

`ifdef DGLK_ARB_FWD_EN
  logic          s1_fwd_q;
  logic [DW-1:0] s1_wdata_q;
`endif

  always_comb begin
    state_d    = state_q;
    wr_gnt     = 1'b0;
    rd_gnt_a   = 1'b0;
    rd_gnt_b   = 1'b0;
    ram_w_ena  = 1'b0;
    ram_w_addr = '0;
    ram_w_data = '0;
    ram_r_addr = r_addr_q;
    case (state_q)
      ST_WAIT: state_d = ST_INIT;
      ST_INIT: begin
        ram_w_ena  = 1'b1;
        ram_w_addr = init_cnt_q;
        if (init_cnt_q == {AW{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        wr_gnt     = wr_req;
        ram_w_ena  = wr_req;
        ram_w_addr = wr_addr;
        ram_w_data = wr_data;
        // A wins when alone, or when both ask and priority points at A.
        if (rd_req_a && (!rd_req_b || !prio_q)) rd_gnt_a = 1'b1;
        else if (rd_req_b)                      rd_gnt_b = 1'b1;
        // The address must reach the RAM in the grant cycle so that data
        // is available for the stage-2 capture one cycle later.
        if (rd_gnt_a)      ram_r_addr = rd_addr_a;
        else if (rd_gnt_b) ram_r_addr = rd_addr_b;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign init_done = (state_q == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT;
      init_cnt_q <= '0;
      prio_q     <= 1'b0;
      r_addr_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_addr_q <= ram_r_addr;
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + {{(AW-1){1'b0}}, 1'b1};
      if (rd_gnt_a)      prio_q <= 1'b1;
      else if (rd_gnt_b) prio_q <= 1'b0;
      s1_vld_q <= rd_gnt_a | rd_gnt_b;
      s1_id_q  <= rd_gnt_b;
    end
  end

`ifdef DGLK_ARB_FWD_EN
  // Capture the colliding write so stage 2 can return it in place of the
  // RAM's pre-write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_fwd_q   <= 1'b0;
      s1_wdata_q <= '0;
    end else begin
      s1_fwd_q   <= ram_w_ena && (ram_w_addr == ram_r_addr);
      s1_wdata_q <= ram_w_data;
    end
  end
  assign ret_data = s1_fwd_q ? s1_wdata_q : ram_r_data;
`else
  assign ret_data = ram_r_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_a  <= 1'b0;
      rd_vld_b  <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_vld_a <= s1_vld_q && !s1_id_q;
      rd_vld_b <= s1_vld_q && s1_id_q;
      if (s1_vld_q && !s1_id_q) rd_data_a <= ret_data;
      if (s1_vld_q && s1_id_q)  rd_data_b <= ret_data;
    end
  end

endmodule

// File: tb/tb_dglk_bram_arbiter.sv
// tb/tb_dglk_bram_arbiter.sv - self-checking bench for dglk_bram_arbiter against a scoreboard model
module tb_dglk_bram_arbiter;
  localparam int DW       = 40;
  localparam int AW       = 4;
  localparam int DEPTH    = 1 << AW;
  localparam int INIT_END = DEPTH + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt;
  logic          rd_req_a = 1'b0, rd_req_b = 1'b0;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic          rd_gnt_a, rd_gnt_b, rd_vld_a, rd_vld_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          ram_w_ena;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;
  logic          init_done;

  dglk_bram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req_a(rd_req_a), .rd_addr_a(rd_addr_a), .rd_gnt_a(rd_gnt_a),
    .rd_vld_a(rd_vld_a), .rd_data_a(rd_data_a),
    .rd_req_b(rd_req_b), .rd_addr_b(rd_addr_b), .rd_gnt_b(rd_gnt_b),
    .rd_vld_b(rd_vld_b), .rd_data_b(rd_data_b),
    .ram_w_ena(ram_w_ena), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // RAM instance: read-first, one-cycle registered read. The seed port fills
  // it with junk while reset is held so that the zero-fill is observable.
  logic [DW-1:0] ram [DEPTH];
  logic          seed_en = 1'b0;
  logic [AW-1:0] seed_addr = '0;
  logic [DW-1:0] seed_data = '0;
  always @(posedge clk) begin
    ram_r_data <= ram[ram_r_addr];
    if (seed_en)        ram[seed_addr]  <= seed_data;
    else if (ram_w_ena) ram[ram_w_addr] <= ram_w_data;
  end

  // Scoreboard model
  int            checks = 0;
  int            errors = 0;
  int            k = 0;             // cycles since reset release
  bit            pref_b = 1'b0;     // requester favoured on the next contended cycle
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            p1_v, p1_id, p2_v, p2_id;
  logic [DW-1:0] p1_d, p2_d;
  logic [DW-1:0] exp_da, exp_db;
  logic [AW-1:0] exp_raddr;
  bit            last_ga, last_gb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; pref_b = 1'b0;
    p1_v = 0; p1_id = 0; p1_d = '0; p2_v = 0; p2_id = 0; p2_d = '0;
    exp_da = '0; exp_db = '0; exp_raddr = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;  // zero-fill completes before any read
  endtask

  // One clock cycle: inputs are already driven (just after a falling edge).
  task automatic cycle();
    bit            run, ega, egb, e_wena;
    logic [AW-1:0] e_waddr, raddr;
    logic [DW-1:0] e_wdata, rdat;
    #1;
    run = (k >= INIT_END);
    ega = run && rd_req_a && (!rd_req_b || !pref_b);
    egb = run && rd_req_b && !ega;
    if (k == 0)            begin e_wena = 0;      e_waddr = '0;                 e_wdata = '0;      end
    else if (k < INIT_END) begin e_wena = 1;      e_waddr = AW'(k - 1);         e_wdata = '0;      end
    else                   begin e_wena = wr_req; e_waddr = wr_addr;            e_wdata = wr_data; end
    if (ega) exp_raddr = rd_addr_a;
    else if (egb) exp_raddr = rd_addr_b;
    if (p2_v && !p2_id) exp_da = p2_d;
    if (p2_v && p2_id)  exp_db = p2_d;
    chk("wr_gnt",     wr_gnt,     run && wr_req);
    chk("rd_gnt_a",   rd_gnt_a,   ega);
    chk("rd_gnt_b",   rd_gnt_b,   egb);
    chk("ram_w_ena",  ram_w_ena,  e_wena);
    chk("ram_w_addr", ram_w_addr, e_waddr);
    chk("ram_w_data", ram_w_data, e_wdata);
    chk("ram_r_addr", ram_r_addr, exp_raddr);
    chk("init_done",  init_done,  run);
    chk("rd_vld_a",   rd_vld_a,   p2_v && !p2_id);
    chk("rd_vld_b",   rd_vld_b,   p2_v && p2_id);
    chk("rd_data_a",  rd_data_a,  exp_da);
    chk("rd_data_b",  rd_data_b,  exp_db);
    raddr = exp_raddr;
    rdat  = mdl_mem[raddr];
`ifdef DGLK_ARB_FWD_EN
    if (run && wr_req && wr_addr == raddr) rdat = wr_data;
`endif
    if (run && wr_req) mdl_mem[wr_addr] = wr_data;
    if (ega) pref_b = 1'b1;
    if (egb) pref_b = 1'b0;
    p2_v = p1_v; p2_id = p1_id; p2_d = p1_d;
    p1_v = ega || egb; p1_id = egb; p1_d = rdat;
    last_ga = ega; last_gb = egb;
    k++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wr_req = 0; rd_req_a = 0; rd_req_b = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    // Seed RAM with junk under reset
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      seed_en = 1; seed_addr = AW'(i); seed_data = {$urandom, $urandom} | 40'h1;
    end
    @(negedge clk);
    seed_en = 0;
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_ram_r_addr", ram_r_addr, '0);
    rst_n = 1;

    // Zero-fill with every request held high: no grants for 17 cycles
    wr_req = 1; wr_addr = 4'd9; wr_data = 40'h55;
    rd_req_a = 1; rd_addr_a = 4'd4; rd_req_b = 1; rd_addr_b = 4'd6;
    for (int i = 0; i < INIT_END; i++) cycle();
    chk("init_done_at_17", init_done, 1'b1);

    // Every address reads back zero
    wr_req = 0; rd_req_b = 0; rd_req_a = 1;
    for (int i = 0; i < DEPTH; i++) begin rd_addr_a = AW'(i); cycle(); end
    idle(2);

    // Write then read back on the next cycle
    wr_req = 1; wr_addr = 4'd3; wr_data = 40'h12_3456_789A;
    cycle();
    wr_req = 0; rd_req_a = 1; rd_addr_a = 4'd3;
    cycle();
    idle(2);
    chk("raw_addr3", rd_data_a, 40'h12_3456_789A);

    // Contended reads on addresses 1 and 2 alternate A,B,... after a lone B read
    wr_req = 1; wr_addr = 4'd1; wr_data = 40'h11_1111_1111; cycle();
    wr_addr = 4'd2; wr_data = 40'h22_2222_2222; cycle();
    wr_req = 0; rd_req_b = 1; rd_addr_b = 4'd0; cycle();
    rd_req_b = 0; idle(2);
    rd_req_a = 1; rd_addr_a = 4'd1; rd_req_b = 1; rd_addr_b = 4'd2;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("alt_first_a", last_ga, (i % 2) == 0);
    end
    idle(2);

    // Same-cycle write and read on address 5 (prior content 0)
    wr_req = 1; wr_addr = 4'd5; wr_data = 40'hAA; rd_req_a = 1; rd_addr_a = 4'd5;
    cycle();
    idle(2);
`ifdef DGLK_ARB_FWD_EN
    chk("collide_5", rd_data_a, 40'hAA);
`else
    chk("collide_5", rd_data_a, 40'h0);
`endif

    // Random traffic honouring the hold-until-granted handshake
    for (int i = 0; i < 300; i++) begin
      wr_req = 1'($urandom); wr_addr = AW'($urandom); wr_data = {$urandom, $urandom};
      if (!rd_req_a || last_ga) begin rd_req_a = 1'($urandom); rd_addr_a = AW'($urandom); end
      if (!rd_req_b || last_gb) begin rd_req_b = 1'($urandom); rd_addr_b = AW'($urandom); end
      cycle();
    end
    idle(2);

    // Reset one cycle after a grant: no return, fill restarts, priority back to A
    rd_req_a = 1; rd_addr_a = 4'd7; rd_req_b = 0; wr_req = 0;
    cycle();
    rd_req_a = 0;
    rst_n = 0;
    #1;
    chk("rst_rd_vld_a", rd_vld_a, 1'b0);
    chk("rst_ram_r_addr_mid", ram_r_addr, '0);
    chk("rst_rd_data_a", rd_data_a, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    idle(INIT_END + 2);
    rd_req_a = 1; rd_addr_a = 4'd1; rd_req_b = 1; rd_addr_b = 4'd2;
    cycle();
    chk("prio_after_reset", last_ga, 1'b1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
